seq_shifter: RTL

- Multi-cycle, parametrised shift/rotate unit; successor to the 4-bit combinational shifter.
- Generalised data width; adds rotate modes, a configurable shift-per-cycle step and valid/ready handshakes on both sides.
- Sits between operand registers and the result bus of the datapath.
- Trades latency for area: one small shift step per cycle instead of a full barrel network.

---
 rtl/shifter_pkg.sv | 25 ++
 rtl/seq_shifter_step.sv | 87 ++++++++
 rtl/seq_shifter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shift/rotate unit: opcodes,
// FSM state encoding and a small opcode legality helper.
package shifter_pkg;

    // Operation codes carried on in_op
    localparam logic [2:0] OP_SLL     = 3'b000;
    localparam logic [2:0] OP_SLL_ALT = 3'b001;  // legacy alias of SLL
    localparam logic [2:0] OP_SRL     = 3'b010;
    localparam logic [2:0] OP_SRA     = 3'b011;
    localparam logic [2:0] OP_ROL     = 3'b100;
    localparam logic [2:0] OP_ROR     = 3'b101;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Opcodes 110 and 111 are reserved and flagged as illegal
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// Combinational single-step shifter: moves 'value' by k positions
// (0..STEP) in the direction selected by 'op'. Only STEP+1 fixed-distance
// candidates are built, so the network stays small for small STEP.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] sll_c [STEP+1];
    logic [WIDTH-1:0] srl_c [STEP+1];
    logic [WIDTH-1:0] sra_c [STEP+1];
    logic [WIDTH-1:0] rol_c [STEP+1];
    logic [WIDTH-1:0] ror_c [STEP+1];

    logic [WIDTH-1:0] sel_sll;
    logic [WIDTH-1:0] sel_srl;
    logic [WIDTH-1:0] sel_sra;
    logic [WIDTH-1:0] sel_rol;
    logic [WIDTH-1:0] sel_ror;

    // One constant-distance candidate per possible step size; the zero and
    // full-width distances are split out so no slice ever goes out of range.
    genvar gi;
    generate
        for (gi = 0; gi <= STEP; gi++) begin : g_cand
            if (gi == 0) begin : g_zero
                assign sll_c[gi] = value;
                assign srl_c[gi] = value;
                assign sra_c[gi] = value;
                assign rol_c[gi] = value;
                assign ror_c[gi] = value;
            end else if (gi >= WIDTH) begin : g_full
                assign sll_c[gi] = '0;
                assign srl_c[gi] = '0;
                assign sra_c[gi] = {WIDTH{value[WIDTH-1]}};
                assign rol_c[gi] = value;
                assign ror_c[gi] = value;
            end else begin : g_part
                assign sll_c[gi] = {value[WIDTH-1-gi:0], {gi{1'b0}}};
                assign srl_c[gi] = {{gi{1'b0}}, value[WIDTH-1:gi]};
                assign sra_c[gi] = {{gi{value[WIDTH-1]}}, value[WIDTH-1:gi]};
                assign rol_c[gi] = {value[WIDTH-1-gi:0], value[WIDTH-1:WIDTH-gi]};
                assign ror_c[gi] = {value[gi-1:0], value[WIDTH-1:gi]};
            end
        end
    endgenerate

    // Pick the candidate matching this cycle's step size for every operation
    always_comb begin
        sel_sll = value;
        sel_srl = value;
        sel_sra = value;
        sel_rol = value;
        sel_ror = value;
        for (int i = 0; i <= STEP; i++) begin
            if (k == KW'(i)) begin
                sel_sll = sll_c[i];
                sel_srl = srl_c[i];
                sel_sra = sra_c[i];
                sel_rol = rol_c[i];
                sel_ror = ror_c[i];
            end
        end
    end

    // Route the selected operation to the output; illegal codes pass through
    always_comb begin
        result = value;
        case (op)
            OP_SLL, OP_SLL_ALT: result = sel_sll;
            OP_SRL:             result = sel_srl;
            OP_SRA:             result = sel_sra;
            OP_ROL:             result = sel_rol;
            OP_ROR:             result = sel_ror;
            default:            result = value;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit. A request is captured in IDLE, shifted
// at most STEP positions per cycle in SHIFT, and presented in DONE until
// the consumer takes it. Handshake outputs come straight from the state
// register, so there is no combinational path from any input.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_illegal
);

    localparam int KW = $clog2(STEP + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [2:0]       op_reg, op_next;
    logic [AW-1:0]    rem_reg, rem_next;
    logic             illegal_reg, illegal_next;

    logic [AW-1:0]    k_amt;
    logic [KW-1:0]    k_step;
    logic [WIDTH-1:0] step_value;
    logic             req_legal;

    assign req_legal = op_legal(in_op);

    // Step size this cycle: a full STEP unless fewer positions remain.
    // When rem >= STEP the constant STEP necessarily fits in AW bits.
    always_comb begin
        if (int'(rem_reg) >= STEP) begin
            k_amt  = AW'(STEP);
            k_step = KW'(STEP);
        end else begin
            k_amt  = rem_reg;
            k_step = KW'(rem_reg);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .value  (data_reg),
        .op     (op_reg),
        .k      (k_step),
        .result (step_value)
    );

    // State, working register, remaining count and illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            data_reg    <= '0;
            op_reg      <= OP_SLL;
            rem_reg     <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            op_reg      <= op_next;
            rem_reg     <= rem_next;
            illegal_reg <= illegal_next;
        end
    end

    // Next-state and datapath update; everything holds unless a state acts
    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        op_next      = op_reg;
        rem_next     = rem_reg;
        illegal_next = illegal_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    data_next    = in_data;
                    op_next      = in_op;
                    illegal_next = !req_legal;
                    if (!req_legal || (in_amt == '0)) begin
                        rem_next   = '0;
                        state_next = ST_DONE;
                    end else begin
                        rem_next   = in_amt;
                        state_next = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                data_next = step_value;
                rem_next  = rem_reg - k_amt;
                if (rem_reg == k_amt) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                // Result stays frozen until the consumer takes it
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign out_valid   = (state_reg == ST_DONE);
    assign out_data    = data_reg;
    assign out_illegal = illegal_reg;

endmodule
